// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types for the TCDM bank responder: payload layout, AMO opcodes, FSM states.
package tcdm_bank_responder_pkg;

  localparam int unsigned DataWidth        = 32;
  localparam int unsigned BeWidth          = DataWidth / 8;
  localparam int unsigned TCDMAddrMemWidth = 8;
  localparam int unsigned ReorderIdWidth   = 4;
  localparam int unsigned CoreIdWidth      = 4;
  localparam int unsigned AmoWidth         = 4;

  typedef logic [DataWidth-1:0]        data_t;
  typedef logic [BeWidth-1:0]          strb_t;
  typedef logic [TCDMAddrMemWidth-1:0] bank_addr_t;
  typedef logic [AmoWidth-1:0]         amo_t;
  typedef logic [ReorderIdWidth-1:0]   reorder_id_t;
  typedef logic [CoreIdWidth-1:0]      core_id_t;

  typedef enum logic [AmoWidth-1:0] {
    AMONone = 4'd0,
    AMOSwap = 4'd1,
    AMOAdd  = 4'd2,
    AMOAnd  = 4'd3,
    AMOOr   = 4'd4,
    AMOXor  = 4'd5,
    AMOMax  = 4'd6,
    AMOMaxu = 4'd7,
    AMOMin  = 4'd8,
    AMOMinu = 4'd9
  } amo_e;

  typedef struct packed {
    reorder_id_t reorder_id;
    core_id_t    core_id;
    amo_t        amo;
    data_t       data;
  } tcdm_payload_t;

  localparam int unsigned PayloadWidth = $bits(tcdm_payload_t);

  typedef enum logic {
    StIdle  = 1'b0,
    StAmoWb = 1'b1
  } state_e;

  // Unused opcodes (10..15) behave as a plain load/store.
  function automatic amo_e amo_decode(input amo_t raw);
    return (raw > amo_t'(AMOMinu)) ? AMONone : amo_e'(raw);
  endfunction

endpackage

// File: rtl/tcdm_bank_responder_amo_alu.sv
// Combinational AMO datapath: produces the value written back after a read-modify-write.
module tcdm_bank_responder_amo_alu
  import tcdm_bank_responder_pkg::*;
(
  input  logic [AmoWidth-1:0]  amo_i,
  input  logic [DataWidth-1:0] old_i,
  input  logic [DataWidth-1:0] operand_i,
  output logic [DataWidth-1:0] new_o
);

  // Select the new memory word; unknown opcodes leave memory unchanged.
  always_comb begin
    new_o = old_i;
    case (amo_e'(amo_i))
      AMOSwap: new_o = operand_i;
      AMOAdd:  new_o = old_i + operand_i;
      AMOAnd:  new_o = old_i & operand_i;
      AMOOr:   new_o = old_i | operand_i;
      AMOXor:  new_o = old_i ^ operand_i;
      AMOMax:  new_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
      AMOMaxu: new_o = (old_i > operand_i) ? old_i : operand_i;
      AMOMin:  new_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
      AMOMinu: new_o = (old_i < operand_i) ? old_i : operand_i;
      default: new_o = old_i;
    endcase
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Bank-side TCDM responder: drives a 1-cycle SRAM, runs AMOs as read/write pairs and
// returns one in-order response per request through a fall-through response FIFO.
module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned NumRespEntries = 2,
  parameter int unsigned AddrMemWidth   = TCDMAddrMemWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AddrMemWidth-1:0] req_addr_i,
  input  logic                    req_wen_i,
  input  logic [BeWidth-1:0]      req_be_i,
  input  logic [PayloadWidth-1:0] req_payload_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [PayloadWidth-1:0] resp_payload_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrMemWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [BeWidth-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned PtrWidth = (NumRespEntries > 1) ? $clog2(NumRespEntries) : 1;
  localparam int unsigned CntWidth = $clog2(NumRespEntries + 1);

  tcdm_payload_t req_pl;
  amo_e          req_amo;
  assign req_pl  = tcdm_payload_t'(req_payload_i);
  assign req_amo = amo_decode(req_pl.amo);

  state_e                  state_q, state_d;
  logic                    inflight_q;
  logic                    is_store_q;
  reorder_id_t             rid_q;
  core_id_t                cid_q;
  amo_e                    amo_q;
  data_t                   operand_q;
  logic [AddrMemWidth-1:0] addr_q;
  data_t                   amo_new;

  tcdm_payload_t           fifo_q [NumRespEntries];
  logic [PtrWidth-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]     count_q;

  logic          accept, push, pop, fifo_empty, pop_stored, write_entry;
  tcdm_payload_t push_pl;

  // Reserve a FIFO slot for every access still waiting on SRAM data, so pushes never overflow.
  assign req_ready_o = !rst_i && (state_q == StIdle) &&
                       ((32'(count_q) + 32'(inflight_q)) < NumRespEntries);
  assign accept      = req_valid_i && req_ready_o;

  tcdm_bank_responder_amo_alu i_amo_alu (
    .amo_i     (amo_q),
    .old_i     (mem_rdata_i),
    .operand_i (operand_q),
    .new_o     (amo_new)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state: an accepted AMO spends exactly one cycle in write-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept && (req_amo != AMONone)) state_d = StAmoWb;
      StAmoWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: SRAM strobe for new requests, or the AMO write-back (dropped under reset).
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = req_addr_i;
    mem_wdata_o = req_pl.data;
    mem_be_o    = '1;
    case (state_q)
      StIdle: begin
        if (accept) begin
          mem_req_o = 1'b1;
          if ((req_amo == AMONone) && req_wen_i) begin
            mem_we_o = 1'b1;
            mem_be_o = req_be_i;
          end
        end
      end
      StAmoWb: begin
        if (!rst_i) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_q;
          mem_wdata_o = amo_new;
        end
      end
      default: ;
    endcase
  end

  // In-flight flag: the SRAM result of an accepted access arrives next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_q <= 1'b0;
    else       inflight_q <= accept;
  end

  // Capture request metadata and AMO operands at acceptance.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      is_store_q <= (req_amo == AMONone) && req_wen_i;
      rid_q      <= req_pl.reorder_id;
      cid_q      <= req_pl.core_id;
      amo_q      <= req_amo;
      operand_q  <= req_pl.data;
      addr_q     <= req_addr_i;
    end
  end

  // Response for the access issued last cycle: stores return zero, loads/AMOs the read word.
  assign push            = inflight_q && !rst_i;
  assign push_pl.reorder_id = rid_q;
  assign push_pl.core_id    = cid_q;
  assign push_pl.amo        = '0;
  assign push_pl.data       = is_store_q ? '0 : mem_rdata_i;

  // Fall-through FIFO: an empty FIFO presents the incoming push directly.
  assign fifo_empty     = (count_q == '0);
  assign resp_valid_o   = !rst_i && (!fifo_empty || push);
  assign resp_payload_o = fifo_empty ? push_pl : fifo_q[rd_ptr_q];
  assign pop            = resp_valid_o && resp_ready_i;
  assign pop_stored     = pop && !fifo_empty;
  assign write_entry    = push && !(fifo_empty && pop);

  // FIFO pointers and occupancy; reset flushes all queued responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (write_entry)
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(NumRespEntries - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
      if (pop_stored)
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(NumRespEntries - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      count_q <= count_q + CntWidth'(write_entry) - CntWidth'(pop_stored);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    if (write_entry) fifo_q[wr_ptr_q] <= push_pl;
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Self-checking bench for tcdm_bank_responder with an SRAM model and a word-level memory model.
module tb_tcdm_bank_responder;
  import tcdm_bank_responder_pkg::*;

  localparam int unsigned NumEntries = 2;
  localparam int unsigned AW         = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                    rst_i, req_valid_i, req_ready_o, req_wen_i;
  logic [AW-1:0]           req_addr_i, mem_addr_o;
  logic [3:0]              req_be_i, mem_be_o;
  logic [PayloadWidth-1:0] req_payload_i, resp_payload_o;
  logic                    resp_valid_o, resp_ready_i, mem_req_o, mem_we_o;
  logic [31:0]             mem_wdata_o, mem_rdata_i;

  tcdm_bank_responder #(.NumRespEntries(NumEntries), .AddrMemWidth(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wen_i(req_wen_i), .req_be_i(req_be_i), .req_payload_i(req_payload_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_payload_o(resp_payload_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;
  int rr_mode = 1;  // 0: hold resp_ready low, 1: high, 2: random

  // Response-side ready driver.
  always begin
    case (rr_mode)
      0:       resp_ready_i = 1'b0;
      1:       resp_ready_i = 1'b1;
      default: resp_ready_i = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk_i);
    #2;
  end

  // SRAM bank model: byte-masked writes, 1-cycle registered read.
  logic [31:0] sram [256];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference model: memory as seen by the requesters, in acceptance order.
  logic [31:0]   ref_mem [256];
  tcdm_payload_t exp_q[$];
  tcdm_payload_t got_q[$];
  bit            amo_pend = 1'b0;
  logic [7:0]    amo_pend_addr;
  logic [31:0]   amo_pend_old;

  function automatic logic [31:0] amo_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1: return b;
      2: return a + b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return ($signed(a) >= $signed(b)) ? a : b;
      7: return (a >= b) ? a : b;
      8: return ($signed(a) <= $signed(b)) ? a : b;
      9: return (a <= b) ? a : b;
      default: return a;
    endcase
  endfunction

  // Monitor: predicts a response for each acceptance and records each delivered response.
  always @(negedge clk_i) begin
    tcdm_payload_t p, e;
    if (rst_i) begin
      // A reset right after an AMO accept cancels its write-back; undelivered responses vanish.
      if (amo_pend) ref_mem[amo_pend_addr] = amo_pend_old;
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    end
    amo_pend = 1'b0;
    if (!rst_i && req_valid_i && req_ready_o) begin
      p = tcdm_payload_t'(req_payload_i);
      e = '0;
      e.reorder_id = p.reorder_id;
      e.core_id    = p.core_id;
      if (p.amo >= 4'd1 && p.amo <= 4'd9) begin
        e.data = ref_mem[req_addr_i];
        amo_pend = 1'b1; amo_pend_addr = req_addr_i; amo_pend_old = e.data;
        ref_mem[req_addr_i] = amo_ref(int'(p.amo), e.data, p.data);
      end else if (req_wen_i) begin
        for (int b = 0; b < 4; b++)
          if (req_be_i[b]) ref_mem[req_addr_i][8*b +: 8] = p.data[8*b +: 8];
      end else begin
        e.data = ref_mem[req_addr_i];
      end
      exp_q.push_back(e);
    end
    if (!rst_i && resp_valid_o && resp_ready_i) begin
      p = tcdm_payload_t'(resp_payload_o);
      got_q.push_back(p);
      $display("resp rid=%0d core=%0d data=%08h", p.reorder_id, p.core_id, p.data);
    end
  end

  // Drive one request (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [7:0] addr, input logic wen, input logic [3:0] be,
                      input logic [3:0] amo, input logic [3:0] rid, input logic [3:0] cid,
                      input logic [31:0] data);
    tcdm_payload_t p;
    bit ok = 1'b0;
    p.reorder_id = rid; p.core_id = cid; p.amo = amo; p.data = data;
    req_valid_i = 1'b1; req_addr_i = addr; req_wen_i = wen; req_be_i = be; req_payload_i = p;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk_i);
      ok = req_ready_o;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready_o=0 for 64 cycles, required 1 (addr %02h)", addr);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  // Let all outstanding responses leave (bounded).
  task automatic drain();
    rr_mode = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (got_q.size() == exp_q.size() && !resp_valid_o) break;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b1; req_addr_i = '0; req_wen_i = 1'b0; req_be_i = '1;
    req_payload_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", req_ready_o); end
    checks++;
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid_o); end
    checks++;
    if ({mem_req_o, mem_we_o} !== 2'b00) begin errors++; $display("FAIL reset_mem: got req/we %b%b required 00", mem_req_o, mem_we_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", req_ready_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_store_load();
    tcdm_payload_t p, g, e;
    send(8'h10, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 32'hDEADBEEF);
    p.reorder_id = 4'd3; p.core_id = 4'd1; p.amo = 4'd0; p.data = 32'h0;
    req_valid_i = 1'b1; req_addr_i = 8'h10; req_wen_i = 1'b0; req_be_i = 4'hF; req_payload_i = p;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b1, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL load_issue: got ready/req/we/addr %b%b%b/%02h required 110/10",
               req_ready_o, mem_req_o, mem_we_o, mem_addr_o);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    e = '0; e.reorder_id = 4'd3; e.core_id = 4'd1; e.data = 32'hDEADBEEF;
    checks++;
    if ({resp_valid_o, resp_payload_o} !== {1'b1, e}) begin
      errors++;
      $display("FAIL load_latency: got valid=%b payload=%h required valid=1 payload=%h", resp_valid_o, resp_payload_o, e);
    end
    @(posedge clk_i); #1;
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL store_load_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL store_load_resp: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_amo();
    tcdm_payload_t g, e;
    send(8'h20, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 32'd5);
    send(8'h20, 1'b0, 4'h0, 4'd2, 4'd1, 4'd2, 32'd7);   // add
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !==
        {1'b0, 1'b1, 1'b1, 4'hF, 8'h20, 32'd12}) begin
      errors++;
      $display("FAIL amo_writeback: got ready=%b req=%b we=%b be=%h addr=%02h wdata=%h required 0 1 1 f 20 0000000c",
               req_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    end
    @(posedge clk_i); #1;
    send(8'h20, 1'b0, 4'h0, 4'd7, 4'd2, 4'd2, 32'd3);            // maxu
    send(8'h21, 1'b1, 4'hF, 4'd0, 4'd3, 4'd2, 32'hFFFFFFFF);
    send(8'h21, 1'b0, 4'h0, 4'd6, 4'd4, 4'd2, 32'd1);            // max signed
    send(8'h21, 1'b0, 4'h0, 4'd8, 4'd5, 4'd2, 32'h80000000);     // min signed
    send(8'h20, 1'b0, 4'h0, 4'd12, 4'd6, 4'd2, 32'h0);           // code 12 acts as a load
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL amo_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL amo_resp: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++;
    if (sram[8'h20] !== 32'd12) begin errors++; $display("FAIL amo_mem20: got %h required 0000000c", sram[8'h20]); end
    checks++;
    if (sram[8'h21] !== 32'h80000000) begin errors++; $display("FAIL amo_mem21: got %h required 80000000", sram[8'h21]); end
  endtask

  task automatic test_byte_store();
    tcdm_payload_t g, e;
    send(8'h30, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 32'h11223344);
    send(8'h30, 1'b1, 4'b0010, 4'd0, 4'd1, 4'd0, 32'h0000AB00);
    send(8'h30, 1'b0, 4'h0, 4'd0, 4'd5, 4'd3, 32'h0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL byte_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL byte_resp: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    checks++;
    if (sram[8'h30] !== 32'h1122AB44) begin errors++; $display("FAIL byte_mem: got %h required 1122ab44", sram[8'h30]); end
  endtask

  task automatic test_backpressure();
    tcdm_payload_t p, g, e, snap;
    int  n_acc = 0;
    bit  acc;
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, $urandom);
    drain();
    exp_q.delete(); got_q.delete();
    rr_mode = 0;
    p = '0; p.reorder_id = 4'd8; p.core_id = 4'd2;
    req_valid_i = 1'b1; req_wen_i = 1'b0; req_be_i = 4'hF; req_addr_i = 8'h40; req_payload_i = p;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      acc = req_ready_o;
      @(posedge clk_i); #1;
      if (acc) begin
        n_acc++;
        req_addr_i = 8'(8'h40 + n_acc);
        p.reorder_id = 4'(8 + n_acc);
        req_payload_i = p;
      end
    end
    checks++;
    if (n_acc !== int'(NumEntries)) begin errors++; $display("FAIL bp_accepts: got %0d required %0d", n_acc, NumEntries); end
    @(negedge clk_i);
    snap = tcdm_payload_t'(resp_payload_o);
    checks++;
    if ({req_ready_o, resp_valid_o} !== 2'b01) begin
      errors++; $display("FAIL bp_full: got ready/valid %b%b required 01", req_ready_o, resp_valid_o);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (resp_payload_o !== snap) begin errors++; $display("FAIL bp_stable: got %h required %h", resp_payload_o, snap); end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    drain();
    send(8'h43, 1'b0, 4'h0, 4'd0, 4'd15, 4'd1, 32'h0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bp_resp: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_in_amo();
    tcdm_payload_t g, e;
    send(8'h50, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 32'd100);
    drain();
    exp_q.delete(); got_q.delete();
    send(8'h50, 1'b0, 4'h0, 4'd2, 4'd7, 4'd3, 32'd1);
    rst_i = 1'b1;   // lands in the write-back cycle
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o} !== 2'b00) begin errors++; $display("FAIL rst_wb_mem: got req/we %b%b required 00", mem_req_o, mem_we_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b required 0", resp_valid_o); end
    checks++;
    if (sram[8'h50] !== 32'd100) begin errors++; $display("FAIL rst_wb_mem_value: got %h required 00000064", sram[8'h50]); end
    @(posedge clk_i); #1;
    send(8'h50, 1'b0, 4'h0, 4'd0, 4'd9, 4'd3, 32'h0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_wb_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rst_wb_resp: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    tcdm_payload_t g, e;
    for (int i = 0; i < 8; i++) send(8'(8'h60 + i), 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, $urandom);
    rr_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(8'(8'h60 + $urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom),
           4'($urandom), 4'($urandom), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
    end
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL random_resp: got %h required %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    for (int a = 8'h60; a < 8'h68; a++) begin
      checks++;
      if (sram[a] !== ref_mem[a]) begin errors++; $display("FAIL random_mem[%02h]: got %h required %h", a, sram[a], ref_mem[a]); end
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_wen_i = 1'b0;
    req_be_i = '0; req_payload_i = '0;
    test_reset();
    test_store_load();
    test_amo();
    test_byte_store();
    test_backpressure();
    test_reset_in_amo();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Target-side end of the tile TCDM interconnect. Accepts one tcdm_payload_t request per cycle for its bank and drives a single-port SRAM bank (1-cycle read latency).
- Executes atomic memory operations (AMOs) as read-modify-write sequences.
- Returns exactly one response per request, carrying the original reorder_id and core_id, through a backpressurable response FIFO.
- One instance per bank, between the tile crossbar and the bank macro.

Parameters:
- NumRespEntries, 2, response FIFO depth; must be >= 2.
- AddrMemWidth, mempool_pkg::TCDMAddrMemWidth (8), bank word-address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_addr_i  in  AddrMemWidth  bank word address
- req_wen_i  in  1  1 = store, 0 = load (AMOs: don't care)
- req_be_i  in  BeWidth (4)  byte enables, stores only
- req_payload_i  in  $bits(tcdm_payload_t)  reorder_id, core_id, amo, data (store data / AMO operand)
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed when valid&&ready
- resp_payload_o  out  $bits(tcdm_payload_t)  echoed reorder_id/core_id, amo=0, data=result
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AddrMemWidth  SRAM address
- mem_wdata_o  out  DataWidth (32)  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enables
- mem_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Reset values:
  - resp_valid_o=0, mem_req_o=0, mem_we_o=0.
  - req_ready_o=0 during reset; it follows the rules below from the first cycle after reset.
  - FIFO empty, FSM IDLE, in-flight flag cleared.
- AMO encoding (payload.amo): 0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor, 6 max (signed), 7 maxu, 8 min (signed), 9 minu.
  - Codes 10–15 are treated as 0.
  - Add wraps modulo 2^32.
- Flow control: req_ready_o = (state==IDLE) && (fifo_count + inflight < NumRespEntries).
  - The FIFO always has space for every in-flight response, so no response is ever dropped.
- Load (amo==0, wen=0), cycle N accept:
  - Same cycle: mem_req_o=1, mem_we_o=0, mem_addr_o=req_addr_i.
  - N+1: mem_rdata_i is pushed to the FIFO with the registered reorder_id/core_id.
  - The FIFO is fall-through, so resp_valid_o is high in N+1 when it was empty.
- Store (amo==0, wen=1):
  - Cycle N: mem_req_o=1, mem_we_o=1, mem_be_o=req_be_i, mem_wdata_o=payload.data.
  - Response with data=0 pushed in N+1 (same latency as a load).
- AMO (amo in 1..9):
  - State IDLE -> AMO_WB on accept; cycle N issues a full-word read.
  - In AMO_WB (N+1): compute new = op(mem_rdata_i, operand); issue write with mem_we_o=1, be=4'hF, same address; push old value as response data; req_ready_o=0; return to IDLE.
  - Next request is accepted in N+2 at earliest, so its access observes the AMO result.
- Ordering: responses leave strictly in acceptance order.
- Read-after-write: a load accepted the cycle after a store or AMO write returns the new value (SRAM write-first ordering across cycles).
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- resp_payload_o must stay stable while resp_valid_o && !resp_ready_i.
- Reset mid-operation (including in AMO_WB):
  - The pending write-back is aborted; mem_req_o=0 in the reset cycle.
  - The FIFO is flushed and in-flight responses are discarded.

Decomposition:
- mempool_pkg: add amo_e enum (4-bit, values above) sized to amo_t; reuse bank_addr_t and tcdm_payload_t.
- Sub-module tcdm_amo_alu: combinational (amo, old, operand) -> new, 32-bit, signed/unsigned compare.
- Response FIFO: existing common-cells fifo_v3 in fall-through mode.

Test Plan:
- Store 0xDEADBEEF, be=4'hF, to addr 0x10; then load 0x10 with reorder_id=3, core_id=1 -> one store response (data 0), then a load response with data 0xDEADBEEF, id 3, core 1; the load response one cycle after its acceptance.
- Mem[0x20]=5, AMO add operand 7 -> response data 5, mem[0x20]=12, req_ready_o=0 in the write-back cycle; AMO maxu operand 3 -> response 12, mem stays 12.
- Mem[0x21]=0xFFFFFFFF (−1), AMO max operand 1 -> response 0xFFFFFFFF, mem=1; AMO min operand 0x80000000 -> mem=0x80000000.
- Byte store be=4'b0010, data 0x0000AB00, onto 0x11223344 -> subsequent load returns 0x1122AB44.
- Hold resp_ready_i=0 and drive back-to-back loads -> exactly NumRespEntries accepted, then req_ready_o=0; release -> responses drain in order and accepts resume.
- Assert rst_i during AMO_WB -> no SRAM write that cycle, resp_valid_o=0 the next cycle, memory holds the pre-AMO value.
